// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one single-ported sync memory between fetch and
// data ports. Optional perf counters enabled by ARB_PERF_CNT_EN. Rev 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_ack,
    output logic [DW-1:0]   if_rdata,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [DW/8-1:0] dm_be,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    output logic            dm_ack,
    output logic [DW-1:0]   dm_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]     perf_if_wait,
    output logic [31:0]     perf_dm_wait
`endif
);

    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
    localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [LW-1:0] LAT_LAST   = LW'(MEM_LAT);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            issue_if, issue_dm, capture;

    logic            mem_en_q, mem_we_q;
    logic [DW/8-1:0] mem_be_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic            if_ack_q, dm_ack_q;
    logic [DW-1:0]   if_rdata_q, dm_rdata_q;

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        starve_d = starve_q;
        issue_if = 1'b0;
        issue_dm = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                lat_d = '0;
                if (dm_req && !(if_req && starve_q == STARVE_TOP)) begin
                    issue_dm = 1'b1;
                    state_d  = BUSY_DM;
                end else if (if_req) begin
                    issue_if = 1'b1;
                    state_d  = BUSY_IF;
                end
                if (issue_if || !if_req)
                    starve_d = '0;
                else if (issue_dm && starve_q != STARVE_TOP)
                    starve_d = starve_q + 1'b1;
            end
            BUSY_IF, BUSY_DM: begin
                // Memory data is valid in the MEM_LAT-th cycle after the strobe.
                if (lat_q == LAT_LAST) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
            mem_en_q <= issue_if | issue_dm;
            if (issue_dm) begin
                mem_we_q    <= dm_we;
                mem_be_q    <= dm_we ? dm_be : '1;
                mem_addr_q  <= dm_addr;
                mem_wdata_q <= dm_wdata;
            end else if (issue_if) begin
                mem_we_q    <= 1'b0;
                mem_be_q    <= '1;
                mem_addr_q  <= if_addr;
                mem_wdata_q <= '0;
            end
            if_ack_q <= capture && (state_q == BUSY_IF);
            dm_ack_q <= capture && (state_q == BUSY_DM);
            if (capture && state_q == BUSY_IF)
                if_rdata_q <= mem_rdata;
            if (capture && state_q == BUSY_DM)
                dm_rdata_q <= mem_we_q ? '0 : mem_rdata;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_q, perf_dm_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_if_q <= '0;
            perf_dm_q <= '0;
        end else begin
            if (if_req && !if_ack_q && perf_if_q != 32'hFFFF_FFFF)
                perf_if_q <= perf_if_q + 32'd1;
            if (dm_req && !dm_ack_q && perf_dm_q != 32'hFFFF_FFFF)
                perf_dm_q <= perf_dm_q + 32'd1;
        end
    end

    assign perf_if_wait = perf_if_q;
    assign perf_dm_wait = perf_dm_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed self-checking bench for mem_port_arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [3:0]  dm_be = '0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_wait, perf_dm_wait;
    logic [31:0] exp_if_wait, exp_dm_wait;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_if_wait = '0;
            exp_dm_wait = '0;
        end else begin
            if (if_req && !if_ack) exp_if_wait = exp_if_wait + 1;
            if (dm_req && !dm_ack) exp_dm_wait = exp_dm_wait + 1;
        end
    end
`endif

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_be     (dm_be),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_wait (perf_if_wait),
        .perf_dm_wait (perf_dm_wait)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a == 32'h40) ? 32'h2402_000A : {a[15:0], ~a[15:0]};
    endfunction

    // Single-cycle-latency memory: read data appears the cycle after mem_en.
    always @(posedge clk)
        if (mem_en && !mem_we) mem_rdata <= memfn(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        step();
        if (v.is_dm) begin
            dm_req = 1'b1; dm_we = v.we; dm_be = v.be;
            dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        step();
        chk("c1_mem_en", {31'd0, mem_en}, 32'd1);
        chk("c1_mem_we", {31'd0, mem_we}, {31'd0, v.we});
        chk("c1_mem_be", {28'd0, mem_be}, {28'd0, v.exp_be});
        chk("c1_mem_addr", mem_addr, v.addr);
        if (v.we) chk("c1_mem_wdata", mem_wdata, v.wdata);
        step();
        chk("c2_mem_en", {31'd0, mem_en}, 32'd0);
        chk("c2_acks", {30'd0, if_ack, dm_ack}, 32'd0);
        step();
        chk("c3_acks", {30'd0, if_ack, dm_ack}, v.is_dm ? 32'd1 : 32'd2);
        chk("c3_rdata", v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
        if_req = 1'b0;
        dm_req = 1'b0;
        step();
        chk("c4_acks", {30'd0, if_ack, dm_ack}, 32'd0);
    endtask

    initial begin
        int acks;
        int grants;
        int cyc;
        logic [31:0] exp_addr;

        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0040, 32'h0,          4'hF, 32'h2402_000A};
        vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF,  4'h3, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 4'h0, 32'h0000_0200, 32'h0,          4'hF, 32'h0200_FDFF};
        vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h0000_1234, 32'h0,          4'hF, 32'h1234_EDCB};
        vecs[4] = '{1'b1, 1'b1, 4'hC, 32'h0000_0008, 32'h1234_5678,  4'hC, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 4'h5, 32'h0000_FFFC, 32'h0,          4'hF, 32'hFFFC_0003};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);
        chk("if_rdata_hold", if_rdata, 32'h1234_EDCB);

        // Both requesters held: dm x4, if, dm x4, if ...
        step();
        if_addr = 32'h80; dm_addr = 32'h300; dm_we = 1'b0;
        if_req = 1'b1; dm_req = 1'b1;
        acks = 0; grants = 0; cyc = 0;
        while (acks < 20 && cyc < 400) begin
            step();
            cyc++;
            if (mem_en) begin
                exp_addr = (grants % 5 == 4) ? 32'h80 : 32'h300;
                chk("grant_order", mem_addr, exp_addr);
                grants++;
            end
            chk("one_ack", {31'd0, if_ack & dm_ack}, 32'd0);
            if (if_ack || dm_ack) acks++;
        end
        chk("starve_acks", acks, 32'd20);
`ifdef ARB_PERF_CNT_EN
        chk("perf_if_wait", perf_if_wait, exp_if_wait);
        chk("perf_dm_wait", perf_dm_wait, exp_dm_wait);
`endif
        if_req = 1'b0; dm_req = 1'b0;
        repeat (3) step();

        // Simultaneous requests with clear starvation count
        if_addr = 32'h44; dm_addr = 32'h304;
        if_req = 1'b1; dm_req = 1'b1;
        step();
        chk("sim_dm_first", mem_addr, 32'h304);
        chk("sim_dm_en", {31'd0, mem_en}, 32'd1);
        step();
        step();
        chk("sim_dm_ack", {30'd0, if_ack, dm_ack}, 32'd1);
        chk("sim_dm_rdata", dm_rdata, 32'h0304_FCFB);
        dm_req = 1'b0;
        step();
        chk("sim_if_issue", {31'd0, mem_en}, 32'd1);
        chk("sim_if_addr", mem_addr, 32'h44);
        step();
        step();
        chk("sim_if_ack", {30'd0, if_ack, dm_ack}, 32'd2);
        chk("sim_if_rdata", if_rdata, 32'h0044_FFBB);
        if_req = 1'b0;
        repeat (2) step();

        // Request withdrawn early still completes
        dm_addr = 32'h10; dm_we = 1'b0; dm_req = 1'b1;
        step();
        dm_req = 1'b0;
        step();
        step();
        chk("drop_dm_ack", {31'd0, dm_ack}, 32'd1);
        chk("drop_dm_rdata", dm_rdata, 32'h0010_FFEF);
        repeat (2) step();

        // Async reset in the middle of a data access
        dm_addr = 32'h20; dm_req = 1'b1;
        step();
        chk("mid_mem_en", {31'd0, mem_en}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("mid_rst_mem_addr", mem_addr, 32'd0);
        chk("mid_rst_dm_rdata", dm_rdata, 32'd0);
        chk("mid_rst_if_rdata", if_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dm_req = 1'b0;
        acks = 0;
        repeat (6) begin
            step();
            if (dm_ack || if_ack || mem_en) acks++;
        end
        chk("no_ack_after_rst", acks, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
